// File: rtl/operational_unit.sv
// Microprogrammed datapath: four general registers, a combinational ALU, registered
// carry/zero flags and an output latch, all driven by a 17-bit control word each clock.
module operational_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [16:0]      control_bus,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             carry_flag,
  output logic             zero_flag
);

  typedef enum logic [2:0] {
    OpPassB = 3'b000,
    OpAdd   = 3'b001,
    OpSub   = 3'b010,
    OpAnd   = 3'b011,
    OpOr    = 3'b100,
    OpXor   = 3'b101,
    OpShl   = 3'b110,
    OpShr   = 3'b111
  } alu_op_e;

  // Control word fields
  logic       flag_we;
  alu_op_e    alu_op;
  logic       reg_we;
  logic [1:0] dst;
  logic [1:0] src_a;
  logic       out_we;
  logic [1:0] b_src;
  logic [4:0] imm5;
  logic [1:0] src_b;

  assign flag_we = control_bus[16];
  assign alu_op  = alu_op_e'(control_bus[15:13]);
  assign reg_we  = control_bus[12];
  assign dst     = control_bus[11:10];
  assign src_a   = control_bus[9:8];
  assign out_we  = control_bus[7];
  assign b_src   = control_bus[6:5];
  assign imm5    = control_bus[4:0];
  assign src_b   = control_bus[1:0];

  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Operands come straight from the register file, so a dst that is also a source
  // naturally reads the pre-edge value.
  always_comb begin
    op_a = regs[src_a];
    op_b = '0;
    unique case (b_src)
      2'b00: op_b = regs[src_b];
      2'b01: op_b = WIDTH'(imm5);
      2'b10: op_b = data_in;
      2'b11: op_b = WIDTH'(1);
      default: op_b = '0;
    endcase
  end

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  // MSB of the widened difference is the unsigned borrow (A < B).
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  // ALU result and carry/borrow selection
  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (alu_op)
      OpPassB: result = op_b;
      OpAdd: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OpSub: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OpAnd: result = op_a & op_b;
      OpOr:  result = op_a | op_b;
      OpXor: result = op_a ^ op_b;
      OpShl: begin
        result = {op_a[WIDTH-2:0], 1'b0};
        carry  = op_a[WIDTH-1];
      end
      OpShr: begin
        result = {1'b0, op_a[WIDTH-1:1]};
        carry  = op_a[0];
      end
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign zero = (result == '0);

  // Register file write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (reg_we) begin
      regs[dst] <= result;
    end
  end

  // Flags hold unless the word explicitly updates them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (flag_we) begin
      carry_flag <= carry;
      zero_flag  <= zero;
    end
  end

  // Output latch with a one-cycle strobe per update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_we;
      if (out_we) begin
        data_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_operational_unit.sv
// Scoreboard bench for operational_unit: each output word pushes its expected
// data/flags; a monitor pops and compares whenever out_valid is seen.
module tb_operational_unit;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] OP_B   = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam logic [1:0] B_REG = 2'b00;
  localparam logic [1:0] B_IMM = 2'b01;
  localparam logic [1:0] B_DIN = 2'b10;
  localparam logic [1:0] B_ONE = 2'b11;

  logic             clock;
  logic             reset;
  logic [16:0]      control_bus;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             carry_flag;
  logic             zero_flag;

  operational_unit #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .control_bus(control_bus),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] d;
    logic             c;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] cw(input logic fw, input logic [2:0] op, input logic rw,
                                     input logic [1:0] dst, input logic [1:0] sa,
                                     input logic ow, input logic [1:0] bs,
                                     input logic [4:0] imm);
    return {fw, op, rw, dst, sa, ow, bs, imm};
  endfunction

  // Drive one word for one clock; output words carry their expected response.
  task automatic issue(input string name, input logic [16:0] w, input logic [WIDTH-1:0] din,
                       input logic [WIDTH-1:0] ed, input logic ec, input logic ez);
    exp_t e;
    control_bus = w;
    data_in     = din;
    if (w[7]) begin
      e.name = name;
      e.d    = ed;
      e.c    = ec;
      e.z    = ez;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare every presented output against the oldest expectation
  always @(negedge clock) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got data 0x%0h with no pending expectation",
                 data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_data"}, 32'(data_out), 32'(e.d));
        check({e.name, "_carry"}, 32'(carry_flag), 32'(e.c));
        check({e.name, "_zero"}, 32'(zero_flag), 32'(e.z));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    control_bus = '0;
    data_in     = '0;
    repeat (2) @(posedge clock);
    #1;
    check("por_data_out", 32'(data_out), 32'h0);
    check("por_out_valid", 32'(out_valid), 32'h0);
    check("por_flags", {30'b0, carry_flag, zero_flag}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: mid-run reset with R1=0x5A and flags 1/1
    issue("t1_r1_load", cw(0, OP_B, 1, 2'd1, 2'd0, 1, B_DIN, 5'd0), 8'h5A, 8'h5A, 0, 0);
    issue("t1_r2_load", cw(0, OP_B, 1, 2'd2, 2'd0, 0, B_DIN, 5'd0), 8'hFF, 8'h00, 0, 0);
    issue("t1_setflags", cw(1, OP_ADD, 0, 2'd0, 2'd2, 0, B_ONE, 5'd0), 8'h00, 8'h00, 0, 0);
    check("t1_flags_pre", {30'b0, carry_flag, zero_flag}, 32'h3);
    check("t1_data_pre", 32'(data_out), 32'h5A);
    control_bus = '0;
    #2;
    reset = 1'b1;
    #1;
    check("t1_rst_data_out", 32'(data_out), 32'h0);
    check("t1_rst_out_valid", 32'(out_valid), 32'h0);
    check("t1_rst_flags", {30'b0, carry_flag, zero_flag}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    issue("t1_read_r1", cw(0, OP_B, 0, 2'd0, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'h00, 0, 0);
    issue("t1_read_r2", cw(0, OP_OR, 0, 2'd0, 2'd2, 1, B_IMM, 5'd0), 8'h00, 8'h00, 0, 0);

    // 2: 0x1F + 0x01
    issue("t2_r0", cw(0, OP_B, 1, 2'd0, 2'd0, 0, B_IMM, 5'h1F), 8'h00, 8'h00, 0, 0);
    issue("t2_r1", cw(0, OP_B, 1, 2'd1, 2'd0, 0, B_IMM, 5'h01), 8'h00, 8'h00, 0, 0);
    issue("t2_add", cw(1, OP_ADD, 1, 2'd2, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'h20, 0, 0);
    issue("t2_read_r2", cw(0, OP_B, 0, 2'd0, 2'd0, 1, B_REG, 5'd2), 8'h00, 8'h20, 0, 0);

    // 3: 0xFF + 1 wraps, then flags hold
    issue("t3_r0", cw(0, OP_B, 1, 2'd0, 2'd0, 0, B_DIN, 5'd0), 8'hFF, 8'h00, 0, 0);
    issue("t3_inc", cw(1, OP_ADD, 1, 2'd0, 2'd0, 1, B_ONE, 5'd0), 8'h00, 8'h00, 1, 1);
    issue("t3_hold", cw(0, OP_B, 1, 2'd1, 2'd0, 1, B_IMM, 5'd3), 8'h00, 8'h03, 1, 1);

    // 4: subtraction with and without borrow
    issue("t4_r0", cw(0, OP_B, 1, 2'd0, 2'd0, 0, B_IMM, 5'd3), 8'h00, 8'h00, 0, 0);
    issue("t4_r1", cw(0, OP_B, 1, 2'd1, 2'd0, 0, B_IMM, 5'd5), 8'h00, 8'h00, 0, 0);
    issue("t4_sub_borrow", cw(1, OP_SUB, 0, 2'd2, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'hFE, 1, 0);
    issue("t4_sub_self", cw(1, OP_SUB, 0, 2'd2, 2'd1, 1, B_REG, 5'd1), 8'h00, 8'h00, 0, 1);

    // 5: shifts and read-before-write
    issue("t5_r3", cw(0, OP_B, 1, 2'd3, 2'd0, 0, B_DIN, 5'd0), 8'h81, 8'h00, 0, 0);
    issue("t5_shl", cw(1, OP_SHL, 0, 2'd0, 2'd3, 1, B_REG, 5'd0), 8'h00, 8'h02, 1, 0);
    issue("t5_shr", cw(1, OP_SHR, 0, 2'd0, 2'd3, 1, B_REG, 5'd0), 8'h00, 8'h40, 1, 0);
    issue("t5_dbl", cw(1, OP_ADD, 1, 2'd3, 2'd3, 1, B_REG, 5'd3), 8'h00, 8'h02, 1, 0);
    issue("t5_read_r3", cw(0, OP_B, 0, 2'd0, 2'd0, 1, B_REG, 5'd3), 8'h00, 8'h02, 1, 0);
    issue("t5_shr_lsb0", cw(1, OP_SHR, 0, 2'd0, 2'd3, 1, B_REG, 5'd0), 8'h00, 8'h01, 0, 0);

    // Logic ops
    issue("lg_r0", cw(0, OP_B, 1, 2'd0, 2'd0, 0, B_DIN, 5'd0), 8'h3C, 8'h00, 0, 0);
    issue("lg_r1", cw(0, OP_B, 1, 2'd1, 2'd0, 0, B_IMM, 5'h0F), 8'h00, 8'h00, 0, 0);
    issue("lg_and", cw(1, OP_AND, 0, 2'd0, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'h0C, 0, 0);
    issue("lg_or", cw(1, OP_OR, 0, 2'd0, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'h3F, 0, 0);
    issue("lg_xor", cw(1, OP_XOR, 0, 2'd0, 2'd0, 1, B_REG, 5'd1), 8'h00, 8'h33, 0, 0);
    issue("lg_and_zero", cw(1, OP_AND, 0, 2'd0, 2'd0, 1, B_IMM, 5'd3), 8'h00, 8'h00, 0, 1);

    // 6: data_in pass-through, strobe lasts exactly one cycle
    issue("t6_din", cw(0, OP_B, 0, 2'd0, 2'd0, 1, B_DIN, 5'd0), 8'hA5, 8'hA5, 0, 1);
    check("t6_valid_high", 32'(out_valid), 32'h1);
    issue("t6_nop", 17'h0, 8'h00, 8'h00, 0, 0);
    check("t6_valid_low", 32'(out_valid), 32'h0);
    check("t6_data_hold", 32'(data_out), 32'hA5);
    check("t6_flags_hold", {30'b0, carry_flag, zero_flag}, 32'h1);

    // Drain: bounded wait for the monitor to consume every expectation
    for (int i = 0; i < 4 && sb.size() != 0; i++) begin
      @(posedge clock);
    end
    @(negedge clock);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
